// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command-frame parser.
// Frame layout: SYNC, CMD, ARG_HI, ARG_LO, CHK where CHK = (CMD+ARG_HI+ARG_LO) mod 256.
package uart_cmd_pkg;

  // Parser FSM states, one per expected frame position.
  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_GET_CMD = 3'd1,
    ST_GET_HI  = 3'd2,
    ST_GET_LO  = 3'd3,
    ST_GET_CHK = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
  localparam int unsigned FRAME_LEN    = 5;
  localparam int unsigned CHK_W        = 8;

  // 8-bit additive checksum of the three payload bytes; carry is dropped.
  function automatic logic [CHK_W-1:0] calc_chk(input logic [7:0] cmd_b,
                                                input logic [7:0] hi_b,
                                                input logic [7:0] lo_b);
    logic [CHK_W-1:0] sum;
    sum = cmd_b + hi_b + lo_b;
    return sum;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout: inter-byte idle timer. Clear has priority over enable;
// expire_o is high while the count sits at TIMEOUT_CYCLES-1.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TO_W           = 16
) (
  input  logic clk,
  input  logic Rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  // Next-count: clear, count up, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {TO_W{1'b0}};
    end else if (en_i) begin
      count_d = count_q + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Timer register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      count_q <= {TO_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 5-byte command frames from the UART byte stream,
// checks the checksum and emits a one-cycle cmd_valid or chk_err pulse.
// Optional inter-byte timeout is compiled in with `define UART_CMD_TIMEOUT_EN;
// without it to_err is constant 0 and the FSM waits indefinitely mid-frame.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TO_W           = 16
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic [15:0] arg,
  output logic        chk_err,
  output logic        to_err,
  output logic [7:0]  frame_cnt
);

  state_e      state_q, state_d;
  logic [7:0]  cmd_tmp_q, cmd_tmp_d;
  logic [7:0]  hi_tmp_q, hi_tmp_d;
  logic [7:0]  lo_tmp_q, lo_tmp_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] arg_q, arg_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        chk_err_q, chk_err_d;
  logic        to_err_q, to_err_d;
  logic        expire_s;

`ifdef UART_CMD_TIMEOUT_EN
  logic timer_clr_s;
  logic timer_en_s;

  assign timer_clr_s = rx_valid || (state_q == ST_HUNT);
  assign timer_en_s  = (state_q != ST_HUNT);

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clk      (clk),
    .Rst_n    (Rst_n),
    .clr_i    (timer_clr_s),
    .en_i     (timer_en_s),
    .expire_o (expire_s)
  );
`else
  logic unused_cfg_s;

  assign unused_cfg_s = (TIMEOUT_CYCLES == 0) ^ (TO_W == 0);
  assign expire_s     = 1'b0;
`endif

  // Next-state and datapath: frame assembly, checksum verdict, timeout abort.
  always_comb begin
    state_d     = state_q;
    cmd_tmp_d   = cmd_tmp_q;
    hi_tmp_d    = hi_tmp_q;
    lo_tmp_d    = lo_tmp_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    cnt_d       = cnt_q;
    cmd_valid_d = 1'b0;
    chk_err_d   = 1'b0;
    to_err_d    = 1'b0;

    if (rx_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (rx_byte == SYNC_BYTE) begin
            state_d = ST_GET_CMD;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_GET_CMD: begin
          cmd_tmp_d = rx_byte;
          state_d   = ST_GET_HI;
        end
        ST_GET_HI: begin
          hi_tmp_d = rx_byte;
          state_d  = ST_GET_LO;
        end
        ST_GET_LO: begin
          lo_tmp_d = rx_byte;
          state_d  = ST_GET_CHK;
        end
        ST_GET_CHK: begin
          if (rx_byte == calc_chk(cmd_tmp_q, hi_tmp_q, lo_tmp_q)) begin
            cmd_valid_d = 1'b1;
            cmd_d       = cmd_tmp_q;
            arg_d       = {hi_tmp_q, lo_tmp_q};
            cnt_d       = cnt_q + 8'd1;
          end else begin
            chk_err_d = 1'b1;
          end
          state_d = ST_HUNT;
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else if (expire_s && (state_q != ST_HUNT)) begin
      // Idle too long mid-frame: drop the partial frame and resynchronise.
      to_err_d  = 1'b1;
      state_d   = ST_HUNT;
      cmd_tmp_d = 8'h00;
      hi_tmp_d  = 8'h00;
      lo_tmp_d  = 8'h00;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; synchronous active-low reset overrides all.
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_q     <= ST_HUNT;
      cmd_tmp_q   <= 8'h00;
      hi_tmp_q    <= 8'h00;
      lo_tmp_q    <= 8'h00;
      cmd_q       <= 8'h00;
      arg_q       <= 16'h0000;
      cnt_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_tmp_q   <= cmd_tmp_d;
      hi_tmp_q    <= hi_tmp_d;
      lo_tmp_q    <= lo_tmp_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      chk_err_q   <= chk_err_d;
      to_err_q    <= to_err_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign arg       = arg_q;
  assign chk_err   = chk_err_q;
  assign to_err    = to_err_q;
  assign frame_cnt = cnt_q;

endmodule
